// File: rtl/mod_exp_engine_if.sv
// Handshake/data bundle between e_finder (plus modulus/base source) and
// mod_exp_engine. The producer drives the operands and the e_done level; the
// engine drives the result, status flags and a state view for debug.
//
// Handshake: e_done is a level held high while e/n/a are valid. The engine
// starts a run on each 0->1 edge of e_done seen while it is idle or done.
// result/err are meaningful while result_valid is high. result_valid stays
// high until the next accepted edge or reset.
interface mod_exp_engine_if #(
    parameter int NW = 32,
    parameter int EW = 65
) ();
    logic [EW-1:0] e;
    logic          e_done;
    logic [NW-1:0] n;
    logic [NW-1:0] a;
    logic [NW-1:0] result;
    logic          result_valid;
    logic          busy;
    logic          err;
    logic [2:0]    state;

    modport master (
        output e, e_done, n, a,
        input  result, result_valid, busy, err, state
    );

    modport slave (
        input  e, e_done, n, a,
        output result, result_valid, busy, err, state
    );
endinterface

// File: rtl/mod_exp_engine.sv
// mod_exp_engine: computes a^e mod n by right-to-left square-and-multiply,
// using two bit-serial interleaved modular multipliers (no hardware
// multiplier). A run starts on a rising edge of e_done.
//
// Build option: define MODEXP_EARLY_EXIT_EN to stop the exponent loop once
// the remaining exponent bits are all zero. Without it every run walks all
// EW exponent bits (constant time). Results are identical either way.
module mod_exp_engine #(
    parameter int NW = 32,
    parameter int EW = 65
) (
    input logic             clk,
    input logic             rst,
    mod_exp_engine_if.slave bus
);

    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(NW - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REDUCE = 3'd1,
        MUL    = 3'd2,
        UPD    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state, state_next;

    logic          e_done_q;
    logic [EW-1:0] e_sh;
    logic [NW-1:0] n_reg;
    logic [NW-1:0] a_reg;
    logic [NW-1:0] base;
    logic [NW-1:0] acc;
    logic [NW-1:0] r1;
    logic [NW-1:0] r2;
    logic [CW-1:0] bit_cnt;
    logic [NW-1:0] result_q;
    logic          result_valid_q;
    logic          busy_q;
    logic          err_q;

`ifndef MODEXP_EARLY_EXIT_EN
    localparam int IW = $clog2(EW);
    logic [IW-1:0] iter_cnt;
`endif

    logic          trigger;
    logic          small_n;
    logic          mm_last;
    logic          loop_end;
    logic [NW-1:0] x1;
    logic [NW-1:0] y1;
    logic [NW-1:0] mm1_next;
    logic [NW-1:0] mm2_next;

    // One interleaved step: r = 2r mod m, then add x mod m if ybit.
    // Operands are below m, so NW+1 bits hold every intermediate.
    function automatic logic [NW-1:0] modmul_step(
        input logic [NW-1:0] r,
        input logic [NW-1:0] x,
        input logic          ybit,
        input logic [NW-1:0] m
    );
        logic [NW:0] t;
        t = {r, 1'b0};
        if (t >= {1'b0, m}) t = t - {1'b0, m};
        if (ybit) begin
            t = t + {1'b0, x};
            if (t >= {1'b0, m}) t = t - {1'b0, m};
        end
        return t[NW-1:0];
    endfunction

    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = busy_q;
    assign bus.err          = err_q;
    assign bus.state        = state;

    // Trigger detection, loop control and multiplier operand selection.
    always_comb begin
        trigger = bus.e_done & ~e_done_q;
        small_n = (bus.n <= NW'(1));
        mm_last = (bit_cnt == '0);
`ifdef MODEXP_EARLY_EXIT_EN
        loop_end = ((e_sh >> 1) == '0);
`else
        loop_end = (iter_cnt == IW'(EW - 1));
`endif
        // REDUCE uses unit 1 as 1*a so that a >= n is folded below n.
        if (state == REDUCE) begin
            x1 = NW'(1);
            y1 = a_reg;
        end else begin
            x1 = base;
            y1 = acc;
        end
        mm1_next = modmul_step(r1, x1, y1[bit_cnt], n_reg);
        mm2_next = modmul_step(r2, base, base[bit_cnt], n_reg);
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (trigger) begin
                    state_next = small_n ? DONE : REDUCE;
                end else begin
                    state_next = IDLE;
                end
            end
            REDUCE: begin
                if (mm_last) begin
`ifdef MODEXP_EARLY_EXIT_EN
                    state_next = (e_sh == '0) ? DONE : MUL;
`else
                    state_next = MUL;
`endif
                end
            end
            MUL: begin
                if (mm_last) state_next = UPD;
            end
            UPD: begin
                state_next = loop_end ? DONE : MUL;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Datapath: operand latch, multiplier accumulators, loop update, outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_done_q       <= 1'b0;
            e_sh           <= '0;
            n_reg          <= '0;
            a_reg          <= '0;
            base           <= '0;
            acc            <= '0;
            r1             <= '0;
            r2             <= '0;
            bit_cnt        <= BIT_LAST;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
`ifndef MODEXP_EARLY_EXIT_EN
            iter_cnt       <= '0;
`endif
        end else begin
            e_done_q <= bus.e_done;
            case (state)
                IDLE, DONE: begin
                    if (state == DONE) begin
                        result_q       <= acc;
                        result_valid_q <= 1'b1;
                        busy_q         <= 1'b0;
                        err_q          <= (n_reg == '0);
                    end
                    if (trigger) begin
                        e_sh           <= bus.e;
                        n_reg          <= bus.n;
                        a_reg          <= bus.a;
                        // acc = 0 is the answer for the n <= 1 shortcut.
                        acc            <= '0;
                        r1             <= '0;
                        r2             <= '0;
                        bit_cnt        <= BIT_LAST;
                        result_valid_q <= 1'b0;
                        err_q          <= 1'b0;
                        busy_q         <= 1'b1;
`ifndef MODEXP_EARLY_EXIT_EN
                        iter_cnt       <= '0;
`endif
                    end
                end
                REDUCE: begin
                    r1      <= mm1_next;
                    bit_cnt <= bit_cnt - 1'b1;
                    if (mm_last) begin
                        base    <= mm1_next;
                        acc     <= NW'(1);
                        r1      <= '0;
                        r2      <= '0;
                        bit_cnt <= BIT_LAST;
                    end
                end
                MUL: begin
                    r1      <= mm1_next;
                    r2      <= mm2_next;
                    bit_cnt <= mm_last ? BIT_LAST : bit_cnt - 1'b1;
                end
                UPD: begin
                    if (e_sh[0]) acc <= r1;
                    base    <= r2;
                    e_sh    <= e_sh >> 1;
                    r1      <= '0;
                    r2      <= '0;
                    bit_cnt <= BIT_LAST;
`ifndef MODEXP_EARLY_EXIT_EN
                    iter_cnt <= iter_cnt + 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
